// File: rtl/spi_slave_frame_decoder_if.sv
// rtl/spi_slave_frame_decoder_if.sv - SPI pins and SFR bank access signals of the frame decoder
interface spi_slave_frame_decoder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  spi_csn;
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  frame_err;

    // Decoder side: it is the SPI slave and the SFR bank master.
    modport slave (
        input  spi_csn, spi_sclk, spi_mosi, tx_data,
        output spi_miso, spi_miso_oe, wr_addr, wr_data, wr_en, rd_addr, rd_en, frame_err
    );

    // Environment side: SPI master pins plus the SFR bank read-data return.
    modport master (
        output spi_csn, spi_sclk, spi_mosi, tx_data,
        input  spi_miso, spi_miso_oe, wr_addr, wr_data, wr_en, rd_addr, rd_en, frame_err
    );
endinterface

// File: rtl/spi_slave_frame_decoder.sv
// rtl/spi_slave_frame_decoder.sv - mode 0 SPI slave decoding header+data frames into SFR strobes
module spi_slave_frame_decoder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int RD_LATENCY  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_slave_frame_decoder_if.slave bus
);
    localparam int HDR_BITS = 16;
    localparam int FL       = HDR_BITS + DATA_WIDTH;
    localparam int LAT_W    = $clog2(RD_LATENCY + 1) + 1;

    localparam logic [5:0]       HDR_LAST = 6'(HDR_BITS - 1);
    localparam logic [5:0]       HDR_CNT  = 6'(HDR_BITS);
    localparam logic [5:0]       FL_LAST  = 6'(FL - 1);
    localparam logic [5:0]       FL_CNT   = 6'(FL);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RD_LATENCY);

    typedef enum logic [2:0] {IDLE, HDR, RD_WAIT, DATA, DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   csn_prev;
    logic                   sclk_prev;
    logic                   csn_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   csn_fall;
    logic                   csn_rise;
    logic                   sclk_rise;
    logic                   sclk_fall;

    logic [5:0]             bit_cnt;
    logic [14:0]            hdr_sr;
    logic [15:0]            hdr_next;
    logic [DATA_WIDTH-1:0]  data_sr;
    logic [DATA_WIDTH:0]    data_next;
    logic [DATA_WIDTH-1:0]  tx_sr;
    logic [LAT_W-1:0]       lat_cnt;
    logic                   rnw_q;
    logic [ADDR_WIDTH-1:0]  addr_q;

    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic                   rd_en_q;
    logic                   frame_err_q;

    logic                   frame_start;
    logic                   frame_stop;
    logic                   cnt_en;
    logic                   hdr_done;
    logic                   load_tx;
    logic                   shift_tx;
    logic                   frame_end;
    logic                   spare_unused;

    // CSN synchroniser resets low so a frame already in progress at reset
    // release is skipped; the resulting rise is seen in IDLE and ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_sync  <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            csn_prev  <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], bus.spi_csn};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            csn_prev  <= csn_s;
            sclk_prev <= sclk_s;
        end
    end

    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign csn_fall  = csn_prev & ~csn_s;
    assign csn_rise  = ~csn_prev & csn_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    assign hdr_next     = {hdr_sr, mosi_s};
    assign data_next    = {data_sr, mosi_s};
    assign spare_unused = ^{hdr_next, data_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A CSN rise outranks any SCLK edge seen in the same clk.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        cnt_en      = 1'b0;
        hdr_done    = 1'b0;
        load_tx     = 1'b0;
        shift_tx    = 1'b0;
        frame_end   = 1'b0;
        if (state_q == IDLE) begin
            if (csn_fall) begin
                frame_start = 1'b1;
                state_d     = HDR;
            end
        end else if (csn_rise) begin
            frame_stop = 1'b1;
            state_d    = IDLE;
        end else begin
            cnt_en = sclk_rise;
            case (state_q)
                HDR: begin
                    if (sclk_rise && bit_cnt == HDR_LAST) begin
                        hdr_done = 1'b1;
                        state_d  = hdr_next[15] ? RD_WAIT : DATA;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_END) begin
                        load_tx = 1'b1;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (sclk_rise && bit_cnt == FL_LAST) begin
                        frame_end = 1'b1;
                        state_d   = DONE;
                    end
                    // The first fall after the header leaves the freshly loaded MSB in place.
                    if (sclk_fall && rnw_q && bit_cnt > HDR_CNT) begin
                        shift_tx = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            hdr_sr      <= '0;
            data_sr     <= '0;
            tx_sr       <= '0;
            lat_cnt     <= '0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;

            if (frame_start) begin
                bit_cnt <= '0;
                tx_sr   <= '0;
                rnw_q   <= 1'b0;
            end else if (cnt_en && bit_cnt != FL_CNT) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            if (cnt_en && state_q == HDR) begin
                hdr_sr <= hdr_next[14:0];
            end
            if (cnt_en && state_q == DATA) begin
                data_sr <= data_next[DATA_WIDTH-1:0];
            end

            if (hdr_done) begin
                rnw_q   <= hdr_next[15];
                addr_q  <= hdr_next[ADDR_WIDTH-1:0];
                lat_cnt <= '0;
                if (hdr_next[15]) begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= hdr_next[ADDR_WIDTH-1:0];
                end
            end else if (state_q == RD_WAIT) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (load_tx) begin
                tx_sr <= bus.tx_data;
            end else if (shift_tx) begin
                tx_sr <= tx_sr << 1;
            end

            if (frame_end && !rnw_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= data_next[DATA_WIDTH-1:0];
            end

            if (frame_stop) begin
                frame_err_q <= (bit_cnt != 6'd0) && (bit_cnt < FL_CNT);
            end
        end
    end

    assign bus.spi_miso    = (state_q == RD_WAIT || state_q == DATA) ? tx_sr[DATA_WIDTH-1] : 1'b0;
    assign bus.spi_miso_oe = (state_q != IDLE);
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.frame_err   = frame_err_q;
endmodule
